// File: rtl/req_gnt_pkg.sv
// Shared types and defaults for the request/grant scheduler.
// Holds the FSM state enum and the default sizing constants.
package req_gnt_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    GRANT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
// Ports: req (requests), ptr (search start), winner (index), valid (any req).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      winner,
  output logic               valid
);

  int j;

  // Walk offsets from far to near so the closest hit to ptr lands last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    j      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        winner = PW'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_gnt_scheduler.sv
// Round-robin request/grant scheduler: IDLE -> PEND -> GRANT, bounded hold.
// Ports: clk, reset (async high), cStart, req, gnt, busy, timeout.
// Optional macro REQ_GNT_SCHED_ASSERT_EN compiles in protocol assertions.
module req_gnt_scheduler
  import req_gnt_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cStart,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_MAX + 1);

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win_q, win_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic                 tmo_d;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic [PW-1:0]        nxt_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign nxt_ptr = (win_q == PW'(NUM_REQ - 1)) ?
                   '0 : win_q + PW'(1);

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cStart && pick_vld) begin
          state_d = PEND;
          win_d   = pick_idx;
        end
      end
      PEND: begin
        if (req[win_q]) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << win_q;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req[win_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
        end else if (cnt_q == CW'(HOLD_MAX - 1)) begin
          // Final permitted cycle: the count lands on HOLD_MAX.
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          tmo_d   = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      timeout <= tmo_d;
    end
  end

`ifdef REQ_GNT_SCHED_ASSERT_EN
  a_onehot: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(gnt))
    else $display("%m: gnt not onehot0 at %0t", $realtime);

  a_accept: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == IDLE && cStart && pick_vld)
    |=> (state_q == PEND && win_q == $past(pick_idx)))
    else $display("%m: accept not latched at %0t", $realtime);

  a_grant: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == PEND && req[win_q]) |=> gnt[win_q])
    else $display("%m: grant missing at %0t", $realtime);

  a_tmo: assert property (
    @(posedge clk) disable iff (reset)
    timeout |-> (cnt_q == CW'(HOLD_MAX)))
    else $display("%m: timeout count wrong at %0t", $realtime);
`endif

endmodule

// File: tb/tb_req_gnt_scheduler.sv
// Scoreboard bench for req_gnt_scheduler with directed scenarios.
// Stimulus pushes expected grants/timeouts; a negedge monitor pops them.
module tb_req_gnt_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cStart = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] g;
    int         c;
  } gexp_t;

  gexp_t gq[$];
  int    tq[$];
  logic [3:0] prev_g = 4'b0;

  req_gnt_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .cStart  (cStart),
    .req     (req),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every new grant and every timeout pulse consumes an entry.
  always @(negedge clk) begin
    if (reset) begin
      prev_g = 4'b0;
    end else begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      if (gnt !== prev_g && gnt !== 4'b0) begin
        check("gap_before_grant", 32'(prev_g), 32'd0);
        if (gq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: got %b expected none", gnt);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          check("grant_value", 32'(gnt), 32'(e.g));
          check("grant_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (timeout) begin
        if (tq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_timeout: got 1 expected 0 cyc %0d",
                   cyc);
        end else begin
          int tc;
          tc = tq.pop_front();
          check("timeout_cycle", 32'(cyc), 32'(tc));
        end
      end
      prev_g = gnt;
    end
  end

  // Called at a negedge; the grant shows two edges after acceptance.
  task automatic grant_cycle(input logic [3:0] r,
                             input logic [3:0] g,
                             input int hold);
    gexp_t e;
    e.g = g;
    e.c = cyc + 2;
    gq.push_back(e);
    req    = r;
    cStart = 1'b1;
    @(negedge clk);
    cStart = 1'b0;
    repeat (hold) @(negedge clk);
    req = 4'b0;
    @(negedge clk);
    check("release_gnt", 32'(gnt), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    gexp_t e;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester, then ptr=2 picks 3 over 0/1, then ptr=0 picks 1.
    grant_cycle(4'b0010, 4'b0010, 3);
    grant_cycle(4'b1011, 4'b1000, 1);
    grant_cycle(4'b0110, 4'b0010, 1);

    // Held 1001 with cStart high: 0, 3, 0, each ending in timeout.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    c = cyc;
    req    = 4'b1001;
    cStart = 1'b1;
    e.g = 4'b0001; e.c = c + 2;  gq.push_back(e);
    e.g = 4'b1000; e.c = c + 12; gq.push_back(e);
    e.g = 4'b0001; e.c = c + 22; gq.push_back(e);
    tq.push_back(c + 10);
    tq.push_back(c + 20);
    tq.push_back(c + 30);
    repeat (30) @(negedge clk);
    req    = 4'b0;
    cStart = 1'b0;
    @(negedge clk);
    check("rr_idle_busy", 32'(busy), 32'd0);
    check("rr_idle_gnt", 32'(gnt), 32'd0);

    // Cancel in PEND: no grant, ptr stays 1 so 1111 grants index 1.
    req    = 4'b0010;
    cStart = 1'b1;
    @(negedge clk);
    check("pend_busy", 32'(busy), 32'd1);
    req    = 4'b0;
    cStart = 1'b0;
    @(negedge clk);
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_gnt", 32'(gnt), 32'd0);
    grant_cycle(4'b1111, 4'b0010, 1);

    // Async reset mid-grant, then restart from ptr=0.
    c = cyc;
    req    = 4'b0100;
    cStart = 1'b1;
    e.g = 4'b0100; e.c = c + 2; gq.push_back(e);
    @(negedge clk);
    cStart = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    #2 reset = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    c      = cyc;
    req    = 4'b1111;
    cStart = 1'b1;
    e.g = 4'b0001; e.c = c + 2; gq.push_back(e);
    @(negedge clk);
    cStart = 1'b0;
    repeat (2) @(negedge clk);
    req = 4'b0;
    @(negedge clk);
    check("post_rst_release", 32'(gnt), 32'd0);

    // cStart with no requests never leaves IDLE.
    cStart = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("noreq_busy", 32'(busy), 32'd0);
      check("noreq_gnt", 32'(gnt), 32'd0);
    end
    cStart = 1'b0;

    repeat (3) @(negedge clk);
    check("grant_queue_empty", 32'(gq.size()), 32'd0);
    check("timeout_queue_empty", 32'(tq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
